// File: rtl/err_stat_acc.sv
// Multi-channel windowed DC/MSE error accumulator for the demodulator error path.
// Every 2^WIN_LOG2 enabled samples it publishes per-channel window sum and mean.
module err_stat_acc #(
  parameter int WIDTH    = 18,
  parameter int NCH      = 2,
  parameter int WIN_LOG2 = 2,
  parameter int SUM_W    = 2*WIDTH+WIN_LOG2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clk_en,
  input  logic                     mode,
  input  logic                     restart,
  input  logic [NCH*WIDTH-1:0]     err,
  output logic [NCH*2*WIDTH-1:0]   mean_out,
  output logic [NCH*SUM_W-1:0]     sum_out,
  output logic                     out_valid,
  output logic                     mode_out,
  output logic [WIN_LOG2-1:0]      win_cnt
);

  localparam int PW = 2*WIDTH;
  localparam logic [WIN_LOG2-1:0] LAST = '1;

  logic [PW-1:0]           r_p_reg  [NCH];
  logic [SUM_W-1:0]        r_acc    [NCH];
  logic [SUM_W-1:0]        r_sum    [NCH];
  logic [PW-1:0]           r_mean   [NCH];
  logic                    r_p_vld;
  logic                    r_p_mode;
  logic                    r_cap_mode;
  logic                    r_out_valid;
  logic                    r_mode_out;
  logic [WIN_LOG2-1:0]     r_win_cnt;

  logic signed [WIDTH-1:0] w_err    [NCH];
  logic signed [PW-1:0]    w_errx   [NCH];
  logic signed [PW-1:0]    w_sq     [NCH];
  logic [PW-1:0]           w_prod   [NCH];
  logic [SUM_W-1:0]        w_ext    [NCH];
  logic [SUM_W-1:0]        w_tot    [NCH];
  logic signed [SUM_W-1:0] w_ashr   [NCH];
  logic [PW-1:0]           w_mean   [NCH];
  logic [WIN_LOG2-1:0]     w_pos;
  logic                    w_first;
  logic                    w_smode;
  logic                    w_last;

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_ch
      assign w_err[g] = $signed(err[g*WIDTH +: WIDTH]);
      assign sum_out[g*SUM_W +: SUM_W] = r_sum[g];
      assign mean_out[g*PW +: PW]      = r_mean[g];
    end
  endgenerate

  // Window position of the sample being captured: committed count plus the one in flight.
  // The window's mode is taken from the input at its first capture and carried with each sample.
  always_comb begin
    w_pos   = r_win_cnt + WIN_LOG2'(r_p_vld);
    w_first = (w_pos == '0);
    w_smode = w_first ? mode : r_cap_mode;
    w_last  = r_p_vld && (r_win_cnt == LAST);
    for (int c = 0; c < NCH; c++) begin
      w_errx[c] = PW'(w_err[c]);
      w_sq[c]   = w_errx[c] * w_errx[c];
      w_prod[c] = w_smode ? w_sq[c] : w_errx[c];
      w_ext[c]  = r_p_mode ? SUM_W'(r_p_reg[c]) : SUM_W'($signed(r_p_reg[c]));
      w_tot[c]  = r_acc[c] + w_ext[c];
      w_ashr[c] = $signed(w_tot[c]) >>> WIN_LOG2;
      w_mean[c] = r_p_mode ? PW'(w_tot[c] >> WIN_LOG2) : PW'(w_ashr[c]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p_vld     <= 1'b0;
      r_p_mode    <= 1'b0;
      r_cap_mode  <= 1'b0;
      r_out_valid <= 1'b0;
      r_mode_out  <= 1'b0;
      r_win_cnt   <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_p_reg[c] <= '0;
        r_acc[c]   <= '0;
        r_sum[c]   <= '0;
        r_mean[c]  <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      if (restart) begin
        r_p_vld   <= 1'b0;
        r_win_cnt <= '0;
        for (int c = 0; c < NCH; c++) begin
          r_p_reg[c] <= '0;
          r_acc[c]   <= '0;
        end
      end else begin
        r_p_vld <= clk_en;
        if (clk_en) begin
          r_p_mode <= w_smode;
          if (w_first) r_cap_mode <= mode;
          for (int c = 0; c < NCH; c++) r_p_reg[c] <= w_prod[c];
        end
        if (r_p_vld) begin
          r_win_cnt <= r_win_cnt + 1'b1;
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_mode_out  <= r_p_mode;
            for (int c = 0; c < NCH; c++) begin
              r_acc[c]  <= '0;
              r_sum[c]  <= w_tot[c];
              r_mean[c] <= w_mean[c];
            end
          end else begin
            for (int c = 0; c < NCH; c++) r_acc[c] <= w_tot[c];
          end
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign mode_out  = r_mode_out;
  assign win_cnt   = r_win_cnt;

endmodule

// File: tb/tb_err_stat_acc.sv
// Bench for err_stat_acc: directed scenarios plus random traffic against a
// window-level arithmetic model of the sum/mean statistics.
module tb_err_stat_acc;
  localparam int WIDTH = 18, NCH = 2, WL = 2, SUM_W = 2*WIDTH+WL, PW = 2*WIDTH;
  localparam int WIN = 1 << WL;

  logic clk = 1'b0, reset_n = 1'b0, clk_en = 1'b0, mode = 1'b0, restart = 1'b0;
  logic [NCH*WIDTH-1:0] err = '0;
  logic [NCH*PW-1:0]    mean_out;
  logic [NCH*SUM_W-1:0] sum_out;
  logic                 out_valid, mode_out;
  logic [WL-1:0]        win_cnt;

  err_stat_acc #(.WIDTH(WIDTH), .NCH(NCH), .WIN_LOG2(WL)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .mode(mode), .restart(restart),
    .err(err), .mean_out(mean_out), .sum_out(sum_out), .out_valid(out_valid),
    .mode_out(mode_out), .win_cnt(win_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int e_in [NCH];

  // model: window contents, pending publication, expected published outputs
  int     n_cap, acc_cnt;
  bit     inflight, wmode, pend, pmode, ev, emode;
  longint wsum [NCH];
  longint psum [NCH];
  longint esum [NCH];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint win_mean(longint s, bit m);
    longint q;
    q = s / WIN;
    if (!m && s < 0 && (s % WIN) != 0) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    n_cap = 0; acc_cnt = 0; inflight = 0; wmode = 0; pend = 0; pmode = 0;
    ev = 0; emode = 0;
    for (int c = 0; c < NCH; c++) begin wsum[c] = 0; psum[c] = 0; esum[c] = 0; end
  endtask

  task automatic model_step();
    longint v;
    ev = 0;
    if (restart) begin
      n_cap = 0; pend = 0; inflight = 0; acc_cnt = 0;
      for (int c = 0; c < NCH; c++) wsum[c] = 0;
    end else begin
      if (inflight) acc_cnt = (acc_cnt + 1) % WIN;
      if (pend) begin
        ev = 1; emode = pmode; pend = 0;
        for (int c = 0; c < NCH; c++) esum[c] = psum[c];
      end
      inflight = clk_en;
      if (clk_en) begin
        if (n_cap == 0) wmode = mode;
        for (int c = 0; c < NCH; c++) begin
          v = longint'(e_in[c]);
          wsum[c] += wmode ? v * v : v;
        end
        n_cap++;
        if (n_cap == WIN) begin
          pend = 1; pmode = wmode; n_cap = 0;
          for (int c = 0; c < NCH; c++) begin psum[c] = wsum[c]; wsum[c] = 0; end
        end
      end
    end
  endtask

  task automatic check_all(string tag);
    longint m, s;
    check({tag, "_valid"}, 64'(out_valid), 64'(ev));
    check({tag, "_wcnt"}, 64'(win_cnt), 64'(acc_cnt));
    check({tag, "_mode"}, 64'(mode_out), 64'(emode));
    for (int c = 0; c < NCH; c++) begin
      s = esum[c];
      m = win_mean(esum[c], emode);
      check($sformatf("%s_sum%0d", tag, c), 64'(sum_out[c*SUM_W +: SUM_W]), 64'(s[SUM_W-1:0]));
      check($sformatf("%s_mean%0d", tag, c), 64'(mean_out[c*PW +: PW]), 64'(m[PW-1:0]));
    end
  endtask

  task automatic cyc(string tag, bit en, bit md, bit rs, int e0, int e1);
    @(negedge clk);
    clk_en = en; mode = md; restart = rs;
    e_in[0] = e0; e_in[1] = e1;
    err = {WIDTH'(e1), WIDTH'(e0)};
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(string tag);
    @(negedge clk);
    clk_en = 0; restart = 0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic int rnd_err();
    case ($urandom_range(0, 5))
      0: return -131072;
      1: return 131071;
      2: return $signed(32'($urandom_range(0, 20))) - 10;
      default: return $signed(32'($urandom_range(0, 262143))) - 131072;
    endcase
  endfunction

  initial begin
    bit md;
    e_in[0] = 0; e_in[1] = 0;
    model_reset();
    #12;
    check_all("rst");
    @(negedge clk) reset_n = 1'b1;

    // DC, enable every 4th clock
    for (int k = 0; k < WIN; k++) begin
      cyc("dc", 1, 0, 0, 100, (k == 3) ? -2 : -3);
      for (int j = 0; j < 3; j++) cyc("dc", 0, 0, 0, 0, 0);
    end
    // MSE extremes
    for (int k = 0; k < WIN; k++) cyc("mse", 1, 1, 0, (k % 2) ? -3 : 3, -131072);
    for (int j = 0; j < 3; j++) cyc("mse", 0, 1, 0, 0, 0);
    // back-to-back ramp
    for (int k = 1; k <= 12; k++) cyc("b2b", 1, 0, 0, k, -k);
    for (int j = 0; j < 3; j++) cyc("b2b", 0, 0, 0, 0, 0);
    // restart coincident with a third sample
    cyc("rs", 1, 0, 0, 5, 5);
    cyc("rs", 1, 0, 0, 5, 5);
    cyc("rs", 1, 0, 1, 5, 5);
    for (int k = 0; k < WIN; k++) cyc("rs", 1, 0, 0, 8, 8);
    for (int j = 0; j < 3; j++) cyc("rs", 0, 0, 0, 0, 0);
    // mode change mid-window
    cyc("mt", 1, 0, 0, 7, -7);
    cyc("mt", 1, 0, 0, -5, 9);
    for (int k = 0; k < WIN + 2; k++) cyc("mt", 1, 1, 0, k - 3, 2 * k);
    for (int j = 0; j < 3; j++) cyc("mt", 0, 1, 0, 0, 0);
    // async reset mid-window
    cyc("ar", 1, 0, 0, 11, 12);
    cyc("ar", 1, 0, 0, 13, 14);
    async_reset("ar_rst");
    for (int k = 0; k < WIN; k++) cyc("ar", 1, 0, 0, 20 + k, -20 - k);
    for (int j = 0; j < 3; j++) cyc("ar", 0, 0, 0, 0, 0);

    // random traffic; mode only flips once a window's first sample is committed
    md = 0;
    for (int i = 0; i < 3000; i++) begin
      if (n_cap >= 2 && $urandom_range(0, 3) == 0) md = ~md;
      if (i == 1500) async_reset("rnd_rst");
      cyc("rnd", ($urandom_range(0, 2) != 0), md, ($urandom_range(0, 40) == 0),
          rnd_err(), rnd_err());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
